rc4_prga_decrypt: RTL
=====================

# rc4_prga_decrypt

RC4 pseudo-random generation and decryption stage. Runs after the key-scheduling stage finishes permuting the S RAM. It walks the permuted S array to produce one keystream byte per message byte, XORs each with the encrypted message ROM, and writes the plaintext to the decrypted-message RAM. The same S RAM port is reused: the key-scheduling stage releases it when its done flag rises.

## Interface
- MSG_LEN, default 32: message length in bytes, 1..256.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; key-scheduling complete (S RAM permuted).
- s_q  in  8  S RAM read data.
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- rom_q  in  8  encrypted-message ROM read data.
- rom_address  out  8  ROM address, equals k.
- d_address  out  8  decrypted RAM address, equals k.
- d_data  out  8  decrypted RAM write data.
- d_wren  out  1  decrypted RAM write enable.
- done  out  1  sticky; all bytes written.
- key_invalid  out  1  sticky; non-ASCII plaintext seen (see Configuration).

## Operation
- Registers: i, j, k (8 bit, reset 0), si, sj, f (8 bit, reset 0), state (reset IDLE).
- Algorithm, per k = 0..MSG_LEN-1:
  - i = i+1
  - j = j+s[i]
  - swap s[i], s[j]
  - f = s[si+sj]
  - dec[k] = f ^ enc[k]
- All sums are mod 256; 8-bit wrap is natural (i 255→0, j overflow discarded, si+sj truncated).
- States, 15 per byte:
  - IDLE: leave when start=1.
  - INC_I: i<=i+1.
  - RD_SI: s_address=i.
  - WAIT_SI.
  - STORE_SI: si<=s_q.
  - CALC_J: j<=j+si.
  - RD_SJ: s_address=j.
  - WAIT_SJ.
  - STORE_SJ: sj<=s_q.
  - WR_SI: s_address=j, s_data=si, s_wren=1.
  - WR_SJ: s_address=i, s_data=sj, s_wren=1.
  - RD_F: s_address=si+sj.
  - WAIT_F.
  - STORE_F: f<=s_q.
  - WR_D: d_data=f^rom_q, d_wren=1.
  - NEXT_K: if k==MSG_LEN-1 go to DONE, else k<=k+1 and go to INC_I.
  - DONE: hold; done=1.
- i==j: both writes target the same address with the same value; this is correct and needs no special case.
- Outputs are decoded combinationally from state and registers. s_address=0 and s_data=0 in states that do not drive them. d_address=rom_address=k always.
- start is ignored outside IDLE. Deasserting start mid-run has no effect.

## Timing
- Memory model: an address driven in state X yields valid q to be sampled in state X+2. WAIT states cover this. rom_q is stable in WR_D because k has been constant for 14 cycles.
- Reset values: s_wren=0, d_wren=0, done=0, key_invalid=0, s_address=0, s_data=0, d_address=0, rom_address=0, d_data=0^rom_q (d_wren low).
- Latency: the edge that samples start=1 in IDLE enters INC_I. done rises exactly 15×MSG_LEN edges later.
- Write enables: exactly one s_wren pulse in each of WR_SI and WR_SJ, and one d_wren pulse in WR_D, per byte. Never asserted in IDLE or DONE.
- done stays high until reset. No restart without reset.
- Reset mid-operation: same-edge return to IDLE, all registers 0, wren low the next cycle. RAM contents are not restored.

## Configuration
- RC4_PRGA_ASCII_CHECK_EN defined:
  - In WR_D, a plaintext byte outside 97..122 ('a'..'z') and not 32 (space) is still written.
  - The FSM then goes to DONE instead of NEXT_K, with key_invalid=1 and done=1 on the same edge.
  - This allows early abort for key search.
- Not defined: key_invalid is tied to 0 and all MSG_LEN bytes are always processed.

## Test plan
- Identity S (s[n]=n), enc[0..2]=0x61,0x62,0x63 → f=2,5,7, so dec=0x63,0x67,0x64. Post-run S has s[2]=3, s[3]=5, s[5]=2.
- MSG_LEN=32, identity S, start held high → done rises exactly 480 edges after start is sampled. 64 s_wren pulses, 32 d_wren pulses with d_address 0..31 in order.
- Reset asserted during WR_SI of byte 3 → next cycle s_wren=0, done=0. Reassert start: processing restarts from k=0 with i=j=0.
- MSG_LEN=256 with an S giving j wrap past 255 → addresses are wrapped mod 256 and i returns to 0 after byte 255. No X on s_address.
- ASCII_CHECK_EN, identity S, enc[0]=0x63 (dec=0x61), enc[1]=0x00 (dec=0x05) → byte 1 written, then done=key_invalid=1. Only 2 d_wren pulses.
- start low for 100 cycles → state stays IDLE, no wren, done=0.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 keystream walk over the permuted S RAM, XOR with the encrypted ROM into the decrypted RAM (optional RC4_PRGA_ASCII_CHECK_EN)
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_q,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    input  logic [7:0] rom_q,
    output logic [7:0] rom_address,
    output logic [7:0] d_address,
    output logic [7:0] d_data,
    output logic       d_wren,
    output logic       done,
    output logic       key_invalid
);
    typedef enum logic [4:0] {
        IDLE, INC_I, RD_SI, WAIT_SI, STORE_SI, CALC_J, RD_SJ, WAIT_SJ, STORE_SJ,
        WR_SI, WR_SJ, RD_F, WAIT_F, STORE_F, WR_D, NEXT_K, DONE
    } state_t;
    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);
    state_t state, next;
    logic [7:0] i, j, k, si, sj, f, f_addr, pt;
    logic bad_pt;
    assign f_addr = si + sj;
    assign pt = f ^ rom_q;
    assign bad_pt = !((pt >= 8'd97 && pt <= 8'd122) || pt == 8'd32);
    // next state: the per-byte sequence is laid out in enum order, so most states just advance
    always_comb begin
        next = state_t'(state + 5'd1);
        if (state == IDLE) next = start ? INC_I : IDLE;
        if (state == NEXT_K) next = (k == LAST_K) ? DONE : INC_I;
        if (state == DONE) next = DONE;
`ifdef RC4_PRGA_ASCII_CHECK_EN
        if (state == WR_D && bad_pt) next = DONE;
`endif
    end
    // outputs decoded from state; idle address/data buses sit at zero
    always_comb begin
        s_address = (state == RD_SI || state == WR_SJ) ? i :
                    (state == RD_SJ || state == WR_SI) ? j :
                    (state == RD_F) ? f_addr : 8'd0;
        s_data = (state == WR_SI) ? si : (state == WR_SJ) ? sj : 8'd0;
        s_wren = state == WR_SI || state == WR_SJ;
        d_wren = state == WR_D;
        done = state == DONE;
        d_data = pt;
        d_address = k;
        rom_address = k;
    end
    // state register and datapath registers, each loaded in its own state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i <= '0;
            j <= '0;
            k <= '0;
            si <= '0;
            sj <= '0;
            f <= '0;
        end else begin
            state <= next;
            if (state == INC_I) i <= i + 8'd1;
            if (state == STORE_SI) si <= s_q;
            if (state == CALC_J) j <= j + si;
            if (state == STORE_SJ) sj <= s_q;
            if (state == STORE_F) f <= s_q;
            if (state == NEXT_K && k != LAST_K) k <= k + 8'd1;
        end
    end
`ifdef RC4_PRGA_ASCII_CHECK_EN
    logic invalid_q;
    // sticky flag raised together with the early jump to DONE on a non-text byte
    always_ff @(posedge clk) begin
        if (reset) invalid_q <= 1'b0;
        else if (state == WR_D && bad_pt) invalid_q <= 1'b1;
    end
    assign key_invalid = invalid_q;
`else
    assign key_invalid = 1'b0;
`endif
endmodule
